// File: rtl/commit_trace_pkg.sv
// Shared types for the commit trace queue: the packed trace record and drop-counter width.
// With COMMIT_TRACE_TIMESTAMP_EN defined, each record also carries a 64-bit stamp.
package commit_trace_pkg;

   localparam int TRACE_DROP_W = 32;
   localparam int TRACE_SEQ_W  = 64;

   typedef struct packed {
      logic [TRACE_SEQ_W-1:0] seq;
      logic [63:0]            pc;
      logic [31:0]            ir;
      logic [1:0]             level;
      logic                   exc;
      logic                   gprw;
      logic [5:0]             gpra;
      logic [63:0]            gprv;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      logic [63:0]            stamp;
`endif
   } trace_rec_t;

   // Saturating add used by the drop counter.
   function automatic logic [TRACE_DROP_W-1:0] drop_sat(input logic [TRACE_DROP_W-1:0] cur,
                                                        input logic [TRACE_DROP_W-1:0] add);
      logic [TRACE_DROP_W:0] sum;
      sum = {1'b0, cur} + {1'b0, add};
      if (sum[TRACE_DROP_W]) begin
         drop_sat = {TRACE_DROP_W{1'b1}};
      end else begin
         drop_sat = sum[TRACE_DROP_W-1:0];
      end
   endfunction

endpackage

// File: rtl/trace_compact.sv
// Combinational lane compactor: packs committing lanes in ascending order into records
// 0..n_in-1 and tags the first one with the bundle's trap/return flag.
module trace_compact
   import commit_trace_pkg::*;
#(
   parameter int pwd  = 4,
   parameter int seqw = 64
) (
   input  logic [seqw-1:0]             seq_base,
   input  logic [pwd-1:0]              cmt,
   input  logic [pwd-1:0][63:0]        cmt_pc,
   input  logic [pwd-1:0][31:0]        cmt_ir,
   input  logic [pwd-1:0][1:0]         cmt_level,
   input  logic [pwd-1:0]              del_gprw,
   input  logic [pwd-1:0][5:0]         del_gpra,
   input  logic [pwd-1:0][63:0]        del_gprv,
   input  logic                        cmt_exc,
   output trace_rec_t [pwd-1:0]        rec,
   output logic [pwd-1:0]              rec_vld,
   output logic [$clog2(pwd+1)-1:0]    n_in
);

   localparam int NW = $clog2(pwd + 1);
   localparam int LW = (pwd > 1) ? $clog2(pwd) : 1;

   logic [NW-1:0] n_s;
   logic [LW-1:0] slot_s;
   logic          exc_pend_s;
   trace_rec_t    r_s;

   // Walk lanes in order; each committing lane claims the next free slot.
   always_comb begin
      rec        = '0;
      rec_vld    = '0;
      n_s        = '0;
      slot_s     = '0;
      exc_pend_s = cmt_exc;
      r_s        = '0;
      for (int i = 0; i < pwd; i++) begin
         if (cmt[i]) begin
            slot_s        = LW'(n_s);
            r_s           = '0;
            r_s.seq       = TRACE_SEQ_W'(seq_base + seqw'(n_s));
            r_s.pc        = cmt_pc[i];
            r_s.ir        = cmt_ir[i];
            r_s.level     = cmt_level[i];
            r_s.exc       = exc_pend_s;
            r_s.gprw      = del_gprw[i];
            r_s.gpra      = del_gpra[i];
            r_s.gprv      = del_gprv[i];
            rec[slot_s]   = r_s;
            rec_vld[slot_s] = 1'b1;
            exc_pend_s    = 1'b0;
            n_s           = n_s + NW'(1);
         end else begin
            n_s = n_s;
         end
      end
      n_in = n_s;
   end

endmodule

// File: rtl/commit_trace_queue.sv
// Commit trace queue: compacts per-lane commits into a circular FIFO drained over valid/ready.
// Overflow drops whole bundles; COMMIT_TRACE_TIMESTAMP_EN adds mcycle stamping of records.
module commit_trace_queue
   import commit_trace_pkg::*;
#(
   parameter int pwd   = 4,
   parameter int depth = 32,
   parameter int seqw  = 64
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        clr,
   input  logic [pwd-1:0]              cmt,
   input  logic [pwd-1:0][63:0]        cmt_pc,
   input  logic [pwd-1:0][31:0]        cmt_ir,
   input  logic [pwd-1:0][1:0]         cmt_level,
   input  logic [pwd-1:0]              del_gprw,
   input  logic [pwd-1:0][5:0]         del_gpra,
   input  logic [pwd-1:0][63:0]        del_gprv,
   input  logic                        cmt_exc,
   output logic                        trc_valid,
   input  logic                        trc_ready,
   output logic [seqw-1:0]             trc_seq,
   output logic [63:0]                 trc_pc,
   output logic [31:0]                 trc_ir,
   output logic [1:0]                  trc_level,
   output logic                        trc_exc,
   output logic                        trc_gprw,
   output logic [5:0]                  trc_gpra,
   output logic [63:0]                 trc_gprv,
   output logic [$clog2(depth):0]      trc_count,
   output logic                        trc_ovf,
   output logic [TRACE_DROP_W-1:0]     trc_drop
`ifdef COMMIT_TRACE_TIMESTAMP_EN
   ,
   input  logic [63:0]                 mcycle,
   output logic [63:0]                 trc_stamp
`endif
);

   localparam int AW = $clog2(depth);
   localparam int PW = AW + 1;
   localparam int NW = $clog2(pwd + 1);

   logic [PW-1:0]             head_q, head_d, tail_q, tail_d, count_q, count_d;
   logic [seqw-1:0]           seq_q, seq_d;
   logic                      ovf_q, ovf_d;
   logic [TRACE_DROP_W-1:0]   drop_q, drop_d;

   trace_rec_t                mem_q [depth];

   trace_rec_t [pwd-1:0]      crec_s;
   logic [pwd-1:0]            cvld_s;
   logic [NW-1:0]             n_in_s;
   logic [PW-1:0]             free_s;
   logic [PW-1:0]             n_acc_s;
   logic                      accept_s, drop_s, pop_s;
   logic [pwd-1:0]            wr_en_s;
   logic [pwd-1:0][AW-1:0]    wr_addr_s;
   trace_rec_t [pwd-1:0]      wr_rec_s;
   trace_rec_t                head_rec_s;

   trace_compact #(.pwd(pwd), .seqw(seqw)) u_compact (
      .seq_base  (seq_q),
      .cmt       (cmt),
      .cmt_pc    (cmt_pc),
      .cmt_ir    (cmt_ir),
      .cmt_level (cmt_level),
      .del_gprw  (del_gprw),
      .del_gpra  (del_gpra),
      .del_gprv  (del_gprv),
      .cmt_exc   (cmt_exc),
      .rec       (crec_s),
      .rec_vld   (cvld_s),
      .n_in      (n_in_s)
   );

   // Admission uses registered occupancy only, so a same-cycle pop never makes room.
   always_comb begin
      free_s   = PW'(depth) - count_q;
      accept_s = !clr && (n_in_s != '0) && (PW'(n_in_s) <= free_s);
      drop_s   = !clr && (PW'(n_in_s) > free_s);
      pop_s    = !clr && (count_q != '0) && trc_ready;
      n_acc_s  = accept_s ? PW'(n_in_s) : '0;

      for (int k = 0; k < pwd; k++) begin
         wr_en_s[k]   = accept_s & cvld_s[k];
         wr_addr_s[k] = tail_q[AW-1:0] + AW'(k);
         wr_rec_s[k]  = crec_s[k];
`ifdef COMMIT_TRACE_TIMESTAMP_EN
         wr_rec_s[k].stamp = mcycle;
`endif
      end

      if (clr) begin
         head_d  = '0;
         tail_d  = '0;
         count_d = '0;
      end else begin
         head_d  = head_q + PW'(pop_s);
         tail_d  = tail_q + n_acc_s;
         count_d = count_q + n_acc_s - PW'(pop_s);
      end

      seq_d  = accept_s ? (seq_q + seqw'(n_in_s)) : seq_q;
      ovf_d  = ovf_q | drop_s;
      drop_d = drop_s ? drop_sat(drop_q, TRACE_DROP_W'(n_in_s)) : drop_q;
   end

   // Control state register with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!rst) begin
         head_q  <= '0;
         tail_q  <= '0;
         count_q <= '0;
         seq_q   <= '0;
         ovf_q   <= 1'b0;
         drop_q  <= '0;
      end else begin
         head_q  <= head_d;
         tail_q  <= tail_d;
         count_q <= count_d;
         seq_q   <= seq_d;
         ovf_q   <= ovf_d;
         drop_q  <= drop_d;
      end
   end

   // Record storage; contents are don't-care until counted as valid.
   always_ff @(posedge clk) begin
      for (int k = 0; k < pwd; k++) begin
         if (wr_en_s[k]) begin
            mem_q[wr_addr_s[k]] <= wr_rec_s[k];
         end
      end
   end

   // First-word-fall-through head view, forced to zero when empty.
   always_comb begin
      if (count_q != '0) begin
         head_rec_s = mem_q[head_q[AW-1:0]];
      end else begin
         head_rec_s = '0;
      end
   end

   assign trc_valid = (count_q != '0);
   assign trc_seq   = head_rec_s.seq[seqw-1:0];
   assign trc_pc    = head_rec_s.pc;
   assign trc_ir    = head_rec_s.ir;
   assign trc_level = head_rec_s.level;
   assign trc_exc   = head_rec_s.exc;
   assign trc_gprw  = head_rec_s.gprw;
   assign trc_gpra  = head_rec_s.gpra;
   assign trc_gprv  = head_rec_s.gprv;
   assign trc_count = count_q;
   assign trc_ovf   = ovf_q;
   assign trc_drop  = drop_q;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
   assign trc_stamp = head_rec_s.stamp;
`endif

endmodule

// File: tb/tb_commit_trace_queue.sv
// Self-checking bench for commit_trace_queue: a reference queue model predicts every head
// record, occupancy, overflow flag and drop count; directed steps follow with a random phase.
module tb_commit_trace_queue;

   localparam int PWD   = 4;
   localparam int DEPTH = 32;

   typedef struct packed {
      logic [63:0] seq;
      logic [63:0] pc;
      logic [31:0] ir;
      logic [1:0]  level;
      logic        exc;
      logic        gprw;
      logic [5:0]  gpra;
      logic [63:0] gprv;
      logic [63:0] stamp;
   } exp_rec_t;

   logic                  clk;
   logic                  rst;
   logic                  clr;
   logic [PWD-1:0]        cmt;
   logic [PWD-1:0][63:0]  cmt_pc;
   logic [PWD-1:0][31:0]  cmt_ir;
   logic [PWD-1:0][1:0]   cmt_level;
   logic [PWD-1:0]        del_gprw;
   logic [PWD-1:0][5:0]   del_gpra;
   logic [PWD-1:0][63:0]  del_gprv;
   logic                  cmt_exc;
   logic                  trc_valid;
   logic                  trc_ready;
   logic [63:0]           trc_seq;
   logic [63:0]           trc_pc;
   logic [31:0]           trc_ir;
   logic [1:0]            trc_level;
   logic                  trc_exc;
   logic                  trc_gprw;
   logic [5:0]            trc_gpra;
   logic [63:0]           trc_gprv;
   logic [5:0]            trc_count;
   logic                  trc_ovf;
   logic [31:0]           trc_drop;
   logic [63:0]           mcycle;
`ifdef COMMIT_TRACE_TIMESTAMP_EN
   logic [63:0]           trc_stamp;
`endif

   exp_rec_t    sb_q[$];
   logic [63:0] m_seq;
   logic        m_ovf;
   logic [31:0] m_drop;
   int          n_cmp;
   int          n_mis;

   commit_trace_queue #(.pwd(PWD), .depth(DEPTH), .seqw(64)) dut (
      .clk       (clk),
      .rst       (rst),
      .clr       (clr),
      .cmt       (cmt),
      .cmt_pc    (cmt_pc),
      .cmt_ir    (cmt_ir),
      .cmt_level (cmt_level),
      .del_gprw  (del_gprw),
      .del_gpra  (del_gpra),
      .del_gprv  (del_gprv),
      .cmt_exc   (cmt_exc),
      .trc_valid (trc_valid),
      .trc_ready (trc_ready),
      .trc_seq   (trc_seq),
      .trc_pc    (trc_pc),
      .trc_ir    (trc_ir),
      .trc_level (trc_level),
      .trc_exc   (trc_exc),
      .trc_gprw  (trc_gprw),
      .trc_gpra  (trc_gpra),
      .trc_gprv  (trc_gprv),
      .trc_count (trc_count),
      .trc_ovf   (trc_ovf),
      .trc_drop  (trc_drop)
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      ,
      .mcycle    (mcycle),
      .trc_stamp (trc_stamp)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_mis++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic check_outputs();
      exp_rec_t e;
      logic     v;
      v = (sb_q.size() != 0);
      e = '0;
      if (v) e = sb_q[0];
      chk("valid", 64'(trc_valid), 64'(v));
      chk("count", 64'(trc_count), 64'(sb_q.size()));
      chk("ovf",   64'(trc_ovf),   64'(m_ovf));
      chk("drop",  64'(trc_drop),  64'(m_drop));
      chk("seq",   trc_seq,        e.seq);
      chk("pc",    trc_pc,         e.pc);
      chk("ir",    64'(trc_ir),    64'(e.ir));
      chk("level", 64'(trc_level), 64'(e.level));
      chk("exc",   64'(trc_exc),   64'(e.exc));
      chk("gprw",  64'(trc_gprw),  64'(e.gprw));
      chk("gpra",  64'(trc_gpra),  64'(e.gpra));
      chk("gprv",  trc_gprv,       e.gprv);
`ifdef COMMIT_TRACE_TIMESTAMP_EN
      chk("stamp", trc_stamp,      e.stamp);
`endif
   endtask

   // Reference behaviour for the coming clock edge, using the pre-edge occupancy.
   task automatic model_update();
      exp_rec_t tmp[$];
      int       n;
      logic     first;
      logic     pop;
      logic [32:0] d;
      if (clr) begin
         sb_q.delete();
         return;
      end
      n = 0;
      first = 1'b1;
      for (int i = 0; i < PWD; i++) begin
         if (cmt[i]) begin
            exp_rec_t r;
            r.seq   = m_seq + 64'(n);
            r.pc    = cmt_pc[i];
            r.ir    = cmt_ir[i];
            r.level = cmt_level[i];
            r.exc   = cmt_exc & first;
            r.gprw  = del_gprw[i];
            r.gpra  = del_gpra[i];
            r.gprv  = del_gprv[i];
`ifdef COMMIT_TRACE_TIMESTAMP_EN
            r.stamp = mcycle;
`else
            r.stamp = 64'd0;
`endif
            first = 1'b0;
            tmp.push_back(r);
            n++;
         end
      end
      pop = trc_ready && (sb_q.size() != 0);
      if (n <= DEPTH - sb_q.size()) begin
         foreach (tmp[j]) sb_q.push_back(tmp[j]);
         m_seq = m_seq + 64'(n);
      end else begin
         m_ovf = 1'b1;
         d = {1'b0, m_drop} + 33'(n);
         m_drop = d[32] ? 32'hFFFF_FFFF : d[31:0];
      end
      if (pop) void'(sb_q.pop_front());
   endtask

   task automatic tick();
      check_outputs();
      model_update();
      @(posedge clk);
      #1;
      mcycle = mcycle + 64'd1;
   endtask

   task automatic drive(input logic [3:0] m, input logic exc);
      cmt     = m;
      cmt_exc = exc;
      for (int i = 0; i < PWD; i++) begin
         cmt_pc[i]    = {$urandom, $urandom};
         cmt_ir[i]    = $urandom;
         cmt_level[i] = 2'($urandom);
         del_gprw[i]  = 1'($urandom);
         del_gpra[i]  = 6'($urandom);
         del_gprv[i]  = {$urandom, $urandom};
      end
   endtask

   task automatic do_reset();
      rst = 1'b0;
      clr = 1'b0;
      trc_ready = 1'b0;
      drive(4'b0000, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      mcycle = mcycle + 64'd2;
      rst = 1'b1;
      sb_q.delete();
      m_seq  = 64'd0;
      m_ovf  = 1'b0;
      m_drop = 32'd0;
   endtask

   initial begin
      n_cmp  = 0;
      n_mis  = 0;
      mcycle = 64'd100;
      m_seq  = 64'd0;
      m_ovf  = 1'b0;
      m_drop = 32'd0;
      rst    = 1'b0;
      clr    = 1'b0;
      trc_ready = 1'b0;
      drive(4'b0000, 1'b0);

      // Reset then idle.
      do_reset();
      tick();
      tick();

      // Sparse compaction: lanes 0 and 2.
      drive(4'b0101, 1'b0);
      cmt_pc[0] = 64'h8000_0000;
      cmt_pc[2] = 64'h8000_0008;
      trc_ready = 1'b1;
      tick();
      drive(4'b0000, 1'b0);
      chk("sparse_seq0", trc_seq, 64'd0);
      chk("sparse_pc0",  trc_pc,  64'h8000_0000);
      tick();
      chk("sparse_seq1", trc_seq, 64'd1);
      chk("sparse_pc1",  trc_pc,  64'h8000_0008);
      tick();
      chk("sparse_empty", 64'(trc_valid), 64'd0);

      // Exception attaches to the lowest committing lane only.
      drive(4'b1010, 1'b1);
      tick();
      drive(4'b0000, 1'b0);
      chk("exc_lane1", 64'(trc_exc), 64'd1);
      tick();
      chk("exc_lane3", 64'(trc_exc), 64'd0);
      tick();

      // Reset with records in flight.
      trc_ready = 1'b0;
      drive(4'b1111, 1'b0);
      tick();
      drive(4'b0110, 1'b1);
      tick();
      drive(4'b0000, 1'b0);
      do_reset();
      tick();
      chk("rst_mid_count", 64'(trc_count), 64'd0);

      // Fill to depth, then a 3-lane bundle is dropped even with a same-cycle pop.
      repeat (8) begin
         drive(4'b1111, 1'b0);
         tick();
      end
      chk("full_count", 64'(trc_count), 64'd32);
      chk("full_valid", 64'(trc_valid), 64'd1);
      drive(4'b0111, 1'b0);
      trc_ready = 1'b1;
      tick();
      drive(4'b0000, 1'b0);
      chk("ovf_flag",  64'(trc_ovf),   64'd1);
      chk("ovf_drop",  64'(trc_drop),  64'd3);
      chk("ovf_count", 64'(trc_count), 64'd31);
      drive(4'b0001, 1'b0);
      tick();
      drive(4'b0000, 1'b0);
      repeat (30) tick();
      chk("seq_after_drop", trc_seq, 64'd32);
      tick();
      tick();

      // Steady single-lane stream across pointer wrap.
      do_reset();
      trc_ready = 1'b1;
      for (int c = 0; c < 100; c++) begin
         drive(4'(1 << (c % 4)), 1'($urandom));
         tick();
      end
      drive(4'b0000, 1'b0);
      chk("wrap_count", 64'(trc_count), 64'd1);
      chk("wrap_seq",   trc_seq,        64'd99);
      tick();

      // Flush mid-stream with a committing bundle.
      trc_ready = 1'b0;
      drive(4'b1111, 1'b0);
      tick();
      drive(4'b0100, 1'b0);
      tick();
      chk("clr_pre_count", 64'(trc_count), 64'd5);
      drive(4'b0011, 1'b0);
      clr = 1'b1;
      tick();
      clr = 1'b0;
      drive(4'b0000, 1'b0);
      chk("clr_count", 64'(trc_count), 64'd0);
      chk("clr_valid", 64'(trc_valid), 64'd0);
      tick();
      drive(4'b1000, 1'b0);
      tick();
      drive(4'b0000, 1'b0);
      chk("clr_seq_kept", trc_seq, 64'd105);

      // Random traffic with occasional flushes.
      for (int c = 0; c < 400; c++) begin
         drive(4'($urandom), 1'($urandom));
         trc_ready = (c < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
         clr = ($urandom_range(0, 59) == 0);
         tick();
      end
      clr = 1'b0;
      trc_ready = 1'b1;
      drive(4'b0000, 1'b0);
      repeat (34) tick();
      chk("final_empty", 64'(trc_valid), 64'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
